// File: rtl/fwd_hazard_unit_pkg.sv
// fwd_hazard_unit_pkg: shared register width, forwarding select codes and bubble field values
package fwd_hazard_unit_pkg;
  localparam int AW = 4;
  typedef enum logic [1:0] {
    FWD_IDEXE = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_t;
  localparam logic [AW-1:0] BUB_RD = '0;
  localparam logic BUB_RW = 1'b0;
  localparam logic BUB_MR = 1'b0;
endpackage

// File: rtl/fwd_hazard_unit_cmp.sv
// fwd_cmp: single-operand forwarding priority comparator, EXE producer beats MEM producer
module fwd_cmp #(
  parameter int AW = fwd_hazard_unit_pkg::AW
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] exe_rd,
  input  logic          exe_rw,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_rw,
  output logic [1:0]    sel
);
  import fwd_hazard_unit_pkg::*;
  always_comb begin
    sel = (exe_rw && exe_rd != '0 && exe_rd == src) ? FWD_EXMEM :
          (mem_rw && mem_rd != '0 && mem_rd == src) ? FWD_WB : FWD_IDEXE;
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects and load-use/flush bubble control; FWD_PATH_EN enables forwarding, else stall on any RAW
module fwd_hazard_unit #(
  parameter int AW = fwd_hazard_unit_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  output logic [1:0]    fwd_sel_a,
  output logic [1:0]    fwd_sel_b,
  output logic          stall,
  output logic          bubble
);
  import fwd_hazard_unit_pkg::*;
  logic [AW-1:0] exe_rd, mem_rd, wb_rd;
  logic          exe_rw, exe_mr, mem_rw, mem_mr, wb_rw;
  logic          adv, hit, unused_ok;
  logic [1:0]    sel_a, sel_b;
  fwd_cmp #(.AW(AW)) u_cmp_a (
    .src(id_rs), .exe_rd(exe_rd), .exe_rw(exe_rw), .mem_rd(mem_rd), .mem_rw(mem_rw), .sel(sel_a)
  );
  fwd_cmp #(.AW(AW)) u_cmp_b (
    .src(id_rt), .exe_rd(exe_rd), .exe_rw(exe_rw), .mem_rd(mem_rd), .mem_rw(mem_rw), .sel(sel_b)
  );
`ifdef FWD_PATH_EN
  assign hit = exe_mr && exe_rd != '0 && (exe_rd == id_rs || exe_rd == id_rt);
`else
  assign hit = sel_a != FWD_IDEXE || sel_b != FWD_IDEXE;
`endif
  assign stall = id_valid && hit && !flush;
  assign adv = id_valid && !stall && !flush;
  assign unused_ok = ^{wb_rd, wb_rw, mem_mr, exe_mr};
  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_rd <= AW'(BUB_RD);
      exe_rw <= BUB_RW;
      exe_mr <= BUB_MR;
      mem_rd <= AW'(BUB_RD);
      mem_rw <= BUB_RW;
      mem_mr <= BUB_MR;
      wb_rd  <= AW'(BUB_RD);
      wb_rw  <= BUB_RW;
      bubble <= 1'b1;
    end else begin
      exe_rd <= adv ? id_rd : AW'(BUB_RD);
      exe_rw <= adv ? id_regwrite : BUB_RW;
      exe_mr <= adv ? id_memread : BUB_MR;
      mem_rd <= exe_rd;
      mem_rw <= exe_rw;
      mem_mr <= exe_mr;
      wb_rd  <= mem_rd;
      wb_rw  <= mem_rw;
      bubble <= !adv;
    end
  end
`ifdef FWD_PATH_EN
  always_ff @(posedge clk) begin
    fwd_sel_a <= (rst && adv) ? sel_a : FWD_IDEXE;
    fwd_sel_b <= (rst && adv) ? sel_b : FWD_IDEXE;
  end
`else
  assign fwd_sel_a = FWD_IDEXE;
  assign fwd_sel_b = FWD_IDEXE;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed table plus randomized stimulus against a distance-based pipeline model
module tb_fwd_hazard_unit;
  typedef struct {
    logic rst, v;
    logic [3:0] rs, rt, rd;
    logic rw, mr, fl, st;
    logic [1:0] sa, sb;
    logic bub;
  } vec_t;
  typedef struct {
    logic [3:0] rd;
    logic rw, mr;
  } ent_t;
  logic clk, rst, id_valid, id_regwrite, id_memread, flush, stall, bubble;
  logic [3:0] id_rs, id_rt, id_rd;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  int errors = 0;
  int checks = 0;
  vec_t tbl[$];
  ent_t pipe[$];
  localparam ent_t BUB = '{rd: 4'd0, rw: 1'b0, mr: 1'b0};
  fwd_hazard_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall), .bubble(bubble)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic add(input logic r, v, input logic [3:0] rs, rt, rd, input logic rw, mr, fl, st,
                     input logic [1:0] sa, sb, input logic bub);
    tbl.push_back('{rst: r, v: v, rs: rs, rt: rt, rd: rd, rw: rw, mr: mr, fl: fl, st: st, sa: sa, sb: sb, bub: bub});
  endtask
  task automatic chk(input string n, input logic [1:0] a, input logic [1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic apply(input vec_t t, input string tag);
    rst = t.rst;
    id_valid = t.v;
    id_rs = t.rs;
    id_rt = t.rt;
    id_rd = t.rd;
    id_regwrite = t.rw;
    id_memread = t.mr;
    flush = t.fl;
    #2;
    chk({tag, " stall"}, {1'b0, stall}, {1'b0, t.st});
    @(posedge clk);
    #1;
    chk({tag, " sel_a"}, fwd_sel_a, t.sa);
    chk({tag, " sel_b"}, fwd_sel_b, t.sb);
    chk({tag, " bubble"}, {1'b0, bubble}, {1'b0, t.bub});
  endtask
  function automatic logic writes(ent_t e, logic [3:0] r);
    return e.rw && e.rd != 4'd0 && e.rd == r;
  endfunction
  function automatic logic [1:0] m_sel(logic [3:0] r);
`ifdef FWD_PATH_EN
    for (int d = 0; d < 2; d++)
      if (writes(pipe[d], r)) return d == 0 ? 2'b10 : 2'b01;
`endif
    return 2'b00;
  endfunction
  function automatic logic m_stall(logic v, logic [3:0] rs, logic [3:0] rt, logic fl);
    if (!v || fl) return 1'b0;
`ifdef FWD_PATH_EN
    return pipe[0].mr && pipe[0].rd != 4'd0 && (pipe[0].rd == rs || pipe[0].rd == rt);
`else
    for (int d = 0; d < 2; d++)
      if (writes(pipe[d], rs) || writes(pipe[d], rt)) return 1'b1;
    return 1'b0;
`endif
  endfunction
  initial begin
`ifdef FWD_PATH_EN
    add(0,0, 0,0,0, 0,0,0, 0,0,0,1);
    add(1,1, 0,0,3, 1,0,0, 0,0,0,0);
    add(1,1, 3,1,6, 1,0,0, 0,2,0,0);
    add(1,1, 0,0,5, 1,0,0, 0,0,0,0);
    add(1,1, 7,0,9, 0,0,0, 0,0,0,0);
    add(1,1, 0,5,8, 1,0,0, 0,0,1,0);
    add(1,1, 0,0,2, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,2, 1,0,0, 0,0,0,0);
    add(1,1, 2,0,10, 0,0,0, 0,2,0,0);
    add(1,1, 0,0,4, 1,1,0, 0,0,0,0);
    add(1,1, 1,4,11, 1,0,0, 1,0,0,1);
    add(1,1, 1,4,11, 1,0,0, 0,0,1,0);
    add(1,1, 0,0,0, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,12, 0,0,0, 0,0,0,0);
    add(1,1, 0,0,4, 1,1,0, 0,0,0,0);
    add(1,1, 4,4,13, 1,0,1, 0,0,0,1);
    add(1,1, 0,0,6, 1,1,0, 0,0,0,0);
    add(0,1, 6,0,14, 1,0,0, 1,0,0,1);
    add(1,1, 6,0,14, 1,0,0, 0,0,0,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,0,1);
`else
    add(0,0, 0,0,0, 0,0,0, 0,0,0,1);
    add(1,1, 0,0,3, 1,0,0, 0,0,0,0);
    add(1,1, 3,1,6, 1,0,0, 1,0,0,1);
    add(1,1, 3,1,6, 1,0,0, 1,0,0,1);
    add(1,1, 3,1,6, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,5, 1,0,0, 0,0,0,0);
    add(1,1, 7,0,9, 0,0,0, 0,0,0,0);
    add(1,1, 0,5,8, 1,0,0, 1,0,0,1);
    add(1,1, 0,5,8, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,4, 1,1,0, 0,0,0,0);
    add(1,1, 1,4,11, 1,0,0, 1,0,0,1);
    add(1,1, 1,4,11, 1,0,0, 1,0,0,1);
    add(1,1, 1,4,11, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,0, 1,0,0, 0,0,0,0);
    add(1,1, 0,0,12, 0,0,0, 0,0,0,0);
    add(1,1, 0,0,4, 1,1,0, 0,0,0,0);
    add(1,1, 4,4,13, 1,0,1, 0,0,0,1);
    add(0,1, 4,0,13, 1,0,0, 1,0,0,1);
    add(1,1, 4,0,13, 1,0,0, 0,0,0,0);
    add(1,0, 0,0,0, 0,0,0, 0,0,0,1);
`endif
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
    pipe = '{BUB, BUB, BUB};
    for (int i = 0; i < 400; i++) begin
      vec_t t;
      ent_t e;
      logic go;
      t.rst = (i == 0) ? 1'b0 : ($urandom_range(0, 31) != 0);
      t.v = (i == 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      t.rs = 4'($urandom_range(0, 7));
      t.rt = 4'($urandom_range(0, 7));
      t.rd = 4'($urandom_range(0, 7));
      t.rw = $urandom_range(0, 3) != 0;
      t.mr = t.rw && $urandom_range(0, 2) == 0;
      t.fl = $urandom_range(0, 7) == 0;
      t.st = m_stall(t.v, t.rs, t.rt, t.fl);
      go = t.rst && t.v && !t.st && !t.fl;
      t.sa = go ? m_sel(t.rs) : 2'b00;
      t.sb = go ? m_sel(t.rt) : 2'b00;
      t.bub = !go;
      e = '{rd: t.rd, rw: t.rw, mr: t.mr};
      if (!t.rst) pipe = '{BUB, BUB, BUB};
      else begin
        pipe.push_front(go ? e : BUB);
        void'(pipe.pop_back());
      end
      apply(t, $sformatf("rnd%0d", i));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Control stage directly upstream of the ALU-operand forwarding muxes in the 5-stage pipeline.
- Tracks destination/write-enable/load flags of instructions in EXE, MEM and WB using its own shadow pipeline registers.
- Produces registered 2-bit select codes for both ALU operand muxes, timed so they are valid while the instruction is in EXE.
- Detects load-use hazards and inserts a one-cycle bubble; honours branch flush.

Parameters:
- AW, 4, register-address width; register 0 is hardwired zero and is never a hazard source.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs  in  AW  source-A register of instruction in ID
- id_rt  in  AW  source-B register of instruction in ID
- id_rd  in  AW  destination register of instruction in ID
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch taken; squash the instruction in ID
- fwd_sel_a  out  2  operand-A mux select for instruction in EXE
- fwd_sel_b  out  2  operand-B mux select for instruction in EXE
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- bubble  out  1  EXE currently holds an injected bubble (registered)

Behaviour:
- Select encoding is fixed: 00 = ID/EXE register data, 01 = write-back (memtoReg) value, 10 = EXE/MEM ALU result; 11 is never driven.
- Shadow stages: exe_{rd,rw,mr}, mem_{rd,rw,mr}, wb_{rd,rw}.
  - Each edge: wb <- mem, mem <- exe.
  - exe <- ID fields when id_valid & !stall & !flush; otherwise exe <- bubble (rw=0, mr=0, rd=0).
- Select generation: computed from the ID operands and registered on the same edge that moves the instruction into EXE (one-cycle latency).
  - Operand A: 10 if exe_rw & exe_rd!=0 & exe_rd==id_rs.
  - Else 01 if mem_rw & mem_rd!=0 & mem_rd==id_rs.
  - Else 00.
  - Operand B: identical rule using id_rt.
  - The younger (EXE) producer always wins over MEM.
  - Bubble or flushed cycles register 00/00.
- WB-to-ID hazards are resolved by the write-first register file; this block raises no select for them.
- Load-use: stall = id_valid & exe_mr & exe_rd!=0 & (exe_rd==id_rs | exe_rd==id_rt).
  - Exactly one bubble is inserted.
  - On the next cycle the load is in MEM, stall deasserts, and the consumer receives select 01.
- flush has priority over stall: stall is forced 0 when flush=1, and a bubble is injected.
- bubble output = registered (stall | flush | !id_valid).
- Reset (rst=0 at an edge):
  - All shadow stages cleared.
  - fwd_sel_a = fwd_sel_b = 00, bubble = 1.
  - stall evaluates to 0 because exe_mr = 0.
  - Reset mid-stall abandons the stall; no pending state survives.

Optional Feature:
- Macro FWD_PATH_EN. Defined: forwarding exactly as above.
- Undefined: fwd_sel_a/fwd_sel_b are tied to 00.
  - stall asserts for any RAW match of id_rs/id_rt against an EXE or MEM producer with rw=1 and rd!=0.
  - Consequence: up to two bubbles per dependency. Flush priority and reset are unchanged.

Decomposition:
- Shared package/define file: AW; select codes FWD_IDEXE=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10; bubble field constants.
- One natural sub-module: fwd_cmp, a combinational single-operand priority comparator (src, exe_rd/rw, mem_rd/rw -> 2-bit select), instantiated twice.

Test Plan:
- ALU RAW back-to-back: ID rd=3 rw=1, then ID rs=3 -> next edge fwd_sel_a=10, fwd_sel_b=00, stall never 1.
- Distance-2 RAW: rd=5 producer, an unrelated instruction, then rt=5 consumer -> fwd_sel_b=01.
- Double hit: EXE rd=2 and MEM rd=2 both writing, consumer rs=2 -> fwd_sel_a=10 (EXE wins).
- Load-use: load rd=4 mr=1, then rt=4 -> stall=1 for exactly one cycle, bubble=1 next cycle, then fwd_sel_b=01.
- Register zero and flush:
  - Producer rd=0 with consumer rs=0 -> sel 00.
  - flush=1 with a concurrent load-use match -> stall=0, bubble injected, sel 00/00.
- Reset mid-stall: drive rst=0 while stall=1 -> next cycle stall=0, bubble=1, sels 00. With FWD_PATH_EN undefined, the distance-1 RAW case gives two stall cycles and sel 00.
